// File: rtl/anti_theft_fsm_multi_pkg.sv
// Shared state encodings and interval register indices for the multi-door
// anti-theft controller.
package anti_theft_pkg;

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_ALARM      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_WAIT_ARM   = 3'd6,
    ST_ILLEGAL    = 3'd7
  } state_e;

  localparam logic [1:0] IDX_ARM    = 2'd0;
  localparam logic [1:0] IDX_DRIVER = 2'd1;
  localparam logic [1:0] IDX_PASS   = 2'd2;
  localparam logic [1:0] IDX_ALARM  = 2'd3;

  // States whose exits depend on the interval down-counter reaching zero.
  function automatic logic is_timed(state_e s);
    return (s == ST_TRIGGERED) || (s == ST_ALARM) || (s == ST_WAIT_ARM);
  endfunction

endpackage

// File: rtl/anti_theft_fsm_multi_interval_timer.sv
// Four programmable intervals plus a loadable, saturating down-counter that
// steps on the 1 Hz enable.
module interval_timer
  import anti_theft_pkg::*;
#(
  parameter int TW        = 4,
  parameter int DEF_ARM    = 6,
  parameter int DEF_DRIVER = 8,
  parameter int DEF_PASS   = 15,
  parameter int DEF_ALARM  = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [1:0]    wsel_i,
  input  logic [TW-1:0] wdata_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [1:0]    load_sel_i,
  input  logic          tick_i,
  output logic [TW-1:0] count_o,
  output logic          zero_o
);

  logic [TW-1:0] interval_q [4];
  logic [TW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this small register file is reset (not left as RAM) because a
      // reset must restore every interval to its power-on default.
      interval_q[IDX_ARM]    <= TW'(DEF_ARM);
      interval_q[IDX_DRIVER] <= TW'(DEF_DRIVER);
      interval_q[IDX_PASS]   <= TW'(DEF_PASS);
      interval_q[IDX_ALARM]  <= TW'(DEF_ALARM);
      count_q                <= '0;
    end else begin
      if (we_i) interval_q[wsel_i] <= wdata_i;
      if (clr_i)                          count_q <= '0;
      else if (load_i)                    count_q <= interval_q[load_sel_i];
      else if (tick_i && count_q != '0)   count_q <= count_q - TW'(1);
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/anti_theft_fsm_multi.sv
// Multi-door anti-theft controller: arming, graced triggering, bounded siren
// re-triggering and driver-door disarm sequencing.
module anti_theft_fsm_multi
  import anti_theft_pkg::*;
#(
  parameter int N_DOORS        = 2,
  parameter int TW             = 4,
  parameter int T_ARM_DELAY    = 6,
  parameter int T_DRIVER_DELAY = 8,
  parameter int T_PASS_DELAY   = 15,
  parameter int T_ALARM_ON     = 10,
  parameter int ALARM_REPEATS  = 3,
  parameter int BLINK_DIV      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic               reprogram,
  input  logic [1:0]         time_param_sel,
  input  logic [TW-1:0]      time_value,
  output logic               status,
  output logic               enable_siren,
  output logic [2:0]         state_o,
  output logic [N_DOORS-1:0] trig_door,
  output logic [TW-1:0]      timer_o
);

  localparam int REP_W = $clog2(ALARM_REPEATS + 1);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [N_DOORS-1:0] DRIVER_ONLY = N_DOORS'(1);

  state_e             state_q, state_d;
  logic [REP_W-1:0]   repeat_q, repeat_d;
  logic [N_DOORS-1:0] trig_q, trig_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               status_q, siren_q;

  logic               tmr_load, tmr_clr, tmr_zero, expired;
  logic [1:0]         tmr_sel;
  logic [TW-1:0]      tmr_count;

  interval_timer #(
    .TW(TW), .DEF_ARM(T_ARM_DELAY), .DEF_DRIVER(T_DRIVER_DELAY),
    .DEF_PASS(T_PASS_DELAY), .DEF_ALARM(T_ALARM_ON)
  ) u_timer (
    .clock(clock), .reset(reset),
    .we_i(reprogram), .wsel_i(time_param_sel), .wdata_i(time_value),
    .clr_i(tmr_clr), .load_i(tmr_load), .load_sel_i(tmr_sel),
    .tick_i(one_hz_enable), .count_o(tmr_count), .zero_o(tmr_zero)
  );

  assign expired = is_timed(state_q) && tmr_zero;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    repeat_d = repeat_q;
    trig_d   = trig_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_sel  = IDX_ARM;

    if (reprogram) begin
      state_d  = ST_ARMED;
      repeat_d = '0;
      trig_d   = '0;
      tmr_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (|door) begin
            state_d  = ST_TRIGGERED;
            trig_d   = door;
            tmr_load = 1'b1;
            tmr_sel  = (door == DRIVER_ONLY) ? IDX_DRIVER : IDX_PASS;
          end else if (ignition) begin
            state_d = ST_DISARMED;
          end
        end
        ST_TRIGGERED: begin
          if (expired) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_sel  = IDX_ALARM;
            repeat_d = REP_W'(1);
          end else if (ignition) begin
            state_d = ST_DISARMED;
          end
        end
        ST_ALARM: begin
          if (ignition) begin
            state_d = ST_DISARMED;
          end else if (expired) begin
            // Another burst only while a door is still open and bursts remain.
            if (door == '0 || repeat_q >= REP_W'(ALARM_REPEATS)) begin
              state_d = ST_ARMED;
            end else begin
              tmr_load = 1'b1;
              tmr_sel  = IDX_ALARM;
              repeat_d = repeat_q + REP_W'(1);
            end
          end
        end
        ST_DISARMED: if (!ignition) state_d = ST_WAIT_OPEN;
        ST_WAIT_OPEN: begin
          if (ignition)     state_d = ST_DISARMED;
          else if (door[0]) state_d = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_d = ST_DISARMED;
          end else if (door == '0) begin
            state_d  = ST_WAIT_ARM;
            tmr_load = 1'b1;
            tmr_sel  = IDX_ARM;
          end
        end
        ST_WAIT_ARM: begin
          if (ignition)      state_d = ST_DISARMED;
          else if (|door)    state_d = ST_WAIT_CLOSE;
          else if (expired)  state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // Blink only advances while remaining in ARMED; any exit restarts it dark.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_q == ST_ARMED && state_d == ST_ARMED) begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (one_hz_enable) begin
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_ARMED;
      repeat_q    <= '0;
      trig_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      status_q    <= 1'b0;
      siren_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      repeat_q    <= repeat_d;
      trig_q      <= trig_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      // Outputs are registered from the next state so they line up with state_q.
      status_q    <= (state_d == ST_TRIGGERED || state_d == ST_ALARM) ? 1'b1 :
                     (state_d == ST_ARMED) ? blink_d : 1'b0;
      siren_q     <= (state_d == ST_ALARM);
    end
  end

  assign status       = status_q;
  assign enable_siren = siren_q;
  assign state_o      = state_q;
  assign trig_door    = trig_q;
  assign timer_o      = tmr_count;

endmodule

// File: doc/anti_theft_fsm_multi.md
Name: anti_theft_fsm_multi

Overview:
Parametrised successor to the single-car anti-theft controller: N door inputs with a designated driver door, an internal programmable interval timer, and bounded siren re-triggering. External timer and interval-select handshakes are absorbed into the block. Sits between debounced sensor inputs, the 1 Hz enable divider, and the siren/status LED drivers.

Parameters:
N_DOORS, 2, number of door inputs (>=2); bit 0 is the driver door
TW, 4, width of interval registers and down-counter
T_ARM_DELAY, 6, reset value of interval 0 (ticks from last door close to ARMED)
T_DRIVER_DELAY, 8, reset value of interval 1 (grace after driver-door-only trigger)
T_PASS_DELAY, 15, reset value of interval 2 (grace when any non-driver door triggers)
T_ALARM_ON, 10, reset value of interval 3 (siren burst length)
ALARM_REPEATS, 3, max siren bursts per trigger event
BLINK_DIV, 2, ticks per status toggle in ARMED

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
one_hz_enable  in  1  single-cycle 1 Hz tick
ignition  in  1  1 = ignition on
door  in  N_DOORS  level, 1 = open; bit 0 driver
reprogram  in  1  load time_value into interval[time_param_sel]
time_param_sel  in  2  interval index 0..3
time_value  in  TW  new interval value
status  out  1  status LED
enable_siren  out  1  siren drive
state_o  out  3  current state encoding
trig_door  out  N_DOORS  door mask latched at trigger
timer_o  out  TW  current down-counter value

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clock edge only.
- Reset: state ARMED, counter 0, repeat count 0, blink 0, trig_door 0, intervals to parameter defaults; status 0, enable_siren 0.
- States (3b): ARMED 0, TRIGGERED 1, ALARM 2, DISARMED 3, WAIT_OPEN 4, WAIT_CLOSE 5, WAIT_ARM 6; 7 -> ARMED next cycle.
- Timer: loaded on entry to a timed state; decrements by 1 on each one_hz_enable while nonzero; expired = (counter==0) in a timed state. Loaded value 0 -> expired on first cycle in the state.
- reprogram: highest priority below reset, from any state: interval[sel] <= time_value, next state ARMED, counter/repeat/trig_door cleared. Held high -> stays ARMED, last write wins.
- ARMED: any door open -> TRIGGERED, trig_door <= door; load interval 1 if door == 1 (driver only), else interval 2. Else ignition -> DISARMED. Door beats ignition.
- TRIGGERED: expired -> ALARM, load interval 3, repeat <= 1. Else ignition -> DISARMED.
- ALARM: ignition -> DISARMED (beats expiry). On expiry: all doors closed -> ARMED; door open and repeat < ALARM_REPEATS -> reload interval 3, repeat+1, stay; repeat == ALARM_REPEATS -> ARMED regardless.
- DISARMED: !ignition -> WAIT_OPEN.
- WAIT_OPEN: ignition -> DISARMED; door[0] open -> WAIT_CLOSE.
- WAIT_CLOSE: ignition -> DISARMED; all doors closed -> WAIT_ARM, load interval 0.
- WAIT_ARM: ignition -> DISARMED; any door open -> WAIT_CLOSE; expired -> ARMED.
- Outputs are registered-state functions only, no input-to-output paths: enable_siren = (ALARM); status = 1 in TRIGGERED/ALARM, blink in ARMED, 0 otherwise.
- Blink: tick counter runs only in ARMED, toggles blink every BLINK_DIV ticks, clears to 0 on leaving ARMED.
- trig_door holds until next trigger or reprogram/reset.
- Counter saturates at 0; no wrap.

Decomposition:
- Package anti_theft_pkg: state encodings, interval index constants (IDX_ARM, IDX_DRIVER, IDX_PASS, IDX_ALARM).
- Sub-module interval_timer: interval register file (4 x TW), programming write port, load/decrement counter, expired flag.

Test Plan:
- Reset, idle 5 ticks -> ARMED, status toggles every 2 ticks, enable_siren 0.
- ARMED, door=01 -> TRIGGERED, timer_o=8, trig_door=01; no ignition, 8 ticks -> ALARM, enable_siren 1, timer_o=10.
- ARMED, door=10 -> timer_o=15; ignition at tick 3 -> DISARMED, status 0, no siren.
- ALARM with door held open -> 3 bursts of 10 ticks, then ARMED; closing door after burst 1 -> ARMED after burst 1.
- ignition on then off -> WAIT_OPEN; door=01 then 00 -> WAIT_ARM timer 6; reopen at tick 3 -> WAIT_CLOSE; close, 6 ticks -> ARMED.
- reprogram sel=3 value=2 in DISARMED -> ARMED next cycle; later ALARM lasts 2 ticks; reset mid-ALARM -> ARMED, intervals back to defaults.
